// File: rtl/asic_sample_sequencer.sv
// asic_sample_sequencer
//   Batch controller for the ASIC function interface. It walks an input
//   sample memory, launches one DAC->XADC conversion per sample, waits for
//   the result, writes it to an output sample memory at the same index, and
//   leaves a settle gap before the next launch.
//
// Ports
//   clk, rst             system clock, asynchronous active-high reset
//   run, abort           batch control from the SoC register block
//   num_samples          batch length, latched when run is accepted
//   busy, done, error    batch status (done is a one-cycle pulse, error sticky)
//   sample_cnt           results stored in the current batch
//   in_mem_*             input sample memory read port (1-cycle read latency)
//   asic_start/data_in   launch pulse and held DAC code to the function interface
//   asic_ready/result    interface idle / result-valid flag and its result
//   out_mem_*            output sample memory write port
module asic_sample_sequencer #(
  parameter int ADDR_WIDTH     = 15,
  parameter int DATA_WIDTH     = 16,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  abort,
  input  logic [ADDR_WIDTH:0]   num_samples,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   sample_cnt,
  output logic [ADDR_WIDTH-1:0] in_mem_addr,
  output logic                  in_mem_en,
  input  logic [DATA_WIDTH-1:0] in_mem_dout,
  output logic                  asic_start,
  output logic [DATA_WIDTH-1:0] asic_data_in,
  input  logic                  asic_ready,
  input  logic [DATA_WIDTH-1:0] asic_result,
  output logic [ADDR_WIDTH-1:0] out_mem_addr,
  output logic                  out_mem_we,
  output logic [DATA_WIDTH-1:0] out_mem_din
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CW-1:0] MAX_N       = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_STORE,
    S_SETTLE,
    S_FINISH
  } state_t;

  state_t                state_reg,  state_next;
  // The memory index and the stored-result count always advance together,
  // so a single register serves as both.
  logic [CW-1:0]         cnt_reg,    cnt_next;
  logic [CW-1:0]         n_reg,      n_next;
  logic [SW-1:0]         settle_reg, settle_next;
  logic [TW-1:0]         tmo_reg,    tmo_next;
  logic                  err_reg,    err_next;
  logic                  done_reg,   done_next;
  logic                  busy_reg,   busy_next;
  logic [DATA_WIDTH-1:0] data_reg,   data_next;
  logic [DATA_WIDTH-1:0] din_reg,    din_next;
  logic [CW-1:0]         cnt_inc;

  assign cnt_inc = cnt_reg + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      n_reg      <= '0;
      settle_reg <= '0;
      tmo_reg    <= '0;
      err_reg    <= 1'b0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      data_reg   <= '0;
      din_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      n_reg      <= n_next;
      settle_reg <= settle_next;
      tmo_reg    <= tmo_next;
      err_reg    <= err_next;
      done_reg   <= done_next;
      busy_reg   <= busy_next;
      data_reg   <= data_next;
      din_reg    <= din_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    n_next      = n_reg;
    settle_next = settle_reg;
    tmo_next    = tmo_reg;
    err_next    = err_reg;
    data_next   = data_reg;
    din_next    = din_reg;
    done_next   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (run) begin
          err_next = 1'b0;
          if (num_samples == '0) begin
            done_next = 1'b1;
          end else begin
            n_next     = (num_samples > MAX_N) ? MAX_N : num_samples;
            cnt_next   = '0;
            state_next = S_FETCH;
          end
        end
      end
      S_FETCH: state_next = S_LOAD;
      S_LOAD: begin
        data_next  = in_mem_dout;
        state_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        if (asic_ready) begin
          tmo_next   = '0;
          state_next = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        // Timeout is checked first here: leaving on the last allowed cycle
        // would still need WAIT_DONE cycles beyond the budget.
        if (tmo_reg == TMO_LAST) begin
          err_next   = 1'b1;
          state_next = S_FINISH;
        end else begin
          tmo_next = tmo_reg + TW'(1);
          if (!asic_ready) state_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (asic_ready) begin
          din_next   = asic_result;
          state_next = S_STORE;
        end else if (tmo_reg == TMO_LAST) begin
          err_next   = 1'b1;
          state_next = S_FINISH;
        end else begin
          tmo_next = tmo_reg + TW'(1);
        end
      end
      S_STORE: begin
        cnt_next = cnt_inc;
        if (cnt_inc == n_reg) begin
          state_next = S_FINISH;
        end else if (SETTLE_CYCLES == 0) begin
          state_next = S_FETCH;
        end else begin
          settle_next = '0;
          state_next  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_reg == SETTLE_LAST) state_next = S_FETCH;
        else settle_next = settle_reg + SW'(1);
      end
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase

    // Abort overrides every transition, including a coincident timeout.
    // FINISH is already on its way out, so it is not re-entered.
    if (abort && state_reg != S_IDLE && state_reg != S_FINISH) begin
      state_next = S_FINISH;
      err_next   = err_reg;
    end

    if (state_next == S_FINISH) done_next = 1'b1;
    busy_next = (state_next != S_IDLE);
  end

  assign busy         = busy_reg;
  assign done         = done_reg;
  assign error        = err_reg;
  assign sample_cnt   = cnt_reg;
  assign in_mem_addr  = cnt_reg[ADDR_WIDTH-1:0];
  assign out_mem_addr = cnt_reg[ADDR_WIDTH-1:0];
  assign asic_data_in = data_reg;
  assign out_mem_din  = din_reg;

  assign in_mem_en  = (state_reg == S_FETCH);
  assign out_mem_we = (state_reg == S_STORE);
  // An abort in the launch cycle must not send a conversion the FSM
  // will never wait for.
  assign asic_start = (state_reg == S_LAUNCH) && asic_ready && !abort;

endmodule

// File: tb/tb_asic_sample_sequencer.sv
module tb_asic_sample_sequencer;
  localparam int AW      = 15;
  localparam int DW      = 16;
  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 4096;
  localparam int DEPTH   = 1 << AW;
  localparam int LAT     = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          abort = 1'b0;
  logic [AW:0]   num_samples = '0;
  logic          busy, done, error;
  logic [AW:0]   sample_cnt;
  logic [AW-1:0] in_mem_addr, out_mem_addr;
  logic          in_mem_en, asic_start, out_mem_we;
  logic [DW-1:0] in_mem_dout, asic_data_in, asic_result, out_mem_din;
  logic          asic_ready;

  asic_sample_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .abort(abort), .num_samples(num_samples),
    .busy(busy), .done(done), .error(error), .sample_cnt(sample_cnt),
    .in_mem_addr(in_mem_addr), .in_mem_en(in_mem_en), .in_mem_dout(in_mem_dout),
    .asic_start(asic_start), .asic_data_in(asic_data_in),
    .asic_ready(asic_ready), .asic_result(asic_result),
    .out_mem_addr(out_mem_addr), .out_mem_we(out_mem_we), .out_mem_din(out_mem_din)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] in_mem  [0:DEPTH-1];
  logic [DW-1:0] out_mem [0:DEPTH-1];
  logic [DW-1:0] key   = '0;
  logic          stuck = 1'b0;

  // Scoreboard: results stored so far in the current batch, event counters.
  int sb_idx = 0;
  int cyc = 0, start_cnt = 0, we_cnt = 0, en_cnt = 0, done_cnt = 0;
  int last_we_cyc = 0, last_start_cyc = 0, last_done_cyc = 0;
  bit launched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int min);
    total++;
    if (act < min) begin
      bad++;
      $display("FAIL %s: got %0d want >= %0d", name, act, min);
    end
  endtask

  // Memory read port and ASIC function interface model. The ASIC takes a
  // launch, drops ready after the launch edge, and returns data^key after
  // LAT clocks. In stuck mode it ignores launches and ready never drops.
  initial begin
    logic          s_start, s_en;
    logic [DW-1:0] s_data, held;
    logic [AW-1:0] s_addr;
    int            acnt;
    acnt = 0;
    held = '0;
    asic_ready  = 1'b1;
    asic_result = '0;
    in_mem_dout = '0;
    forever begin
      @(negedge clk);
      s_start = asic_start;
      s_data  = asic_data_in;
      s_en    = in_mem_en;
      s_addr  = in_mem_addr;
      @(posedge clk);
      #1;
      if (s_en) in_mem_dout = in_mem[s_addr];
      if (acnt > 0) begin
        acnt--;
        if (acnt == 0) begin
          asic_result = held ^ key;
          asic_ready  = 1'b1;
        end
      end else if (s_start && !stuck) begin
        held       = s_data;
        asic_ready = 1'b0;
        acnt       = LAT;
      end
    end
  end

  // Per-cycle compare against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        launched = 0;
        continue;
      end
      if (busy) chk("sample_cnt_track", sample_cnt, sb_idx);
      if (in_mem_en) begin
        en_cnt++;
        chk("fetch_addr", in_mem_addr, sb_idx % DEPTH);
        if (sb_idx > 0) chk_ge("settle_gap", cyc - last_we_cyc, SETTLE);
      end
      if (asic_start) begin
        start_cnt++;
        last_start_cyc = cyc;
        chk("launch_data", asic_data_in, in_mem[sb_idx % DEPTH]);
        launched = 1;
      end else if (launched) begin
        chk("data_hold", asic_data_in, in_mem[sb_idx % DEPTH]);
      end
      if (out_mem_we) begin
        we_cnt++;
        last_we_cyc = cyc;
        chk("store_addr", out_mem_addr, sb_idx % DEPTH);
        chk("store_data", out_mem_din, in_mem[sb_idx % DEPTH] ^ key);
        out_mem[out_mem_addr] = out_mem_din;
        $display("store idx=%0d data=%04h", out_mem_addr, out_mem_din);
        sb_idx++;
        launched = 0;
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
        launched = 0;
        $display("done cnt=%0d error=%0b", sample_cnt, error);
      end
    end
  end

  task automatic start_batch(input int n);
    @(posedge clk); #1;
    num_samples = (AW+1)'(n);
    run    = 1'b1;
    sb_idx = 0;
    @(posedge clk); #1;
    run = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk(name, (done_cnt >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
    end
  endtask

  initial begin
    int d0, s0, w0, e0, k;

    // Reset state
    #3;
    chk("rst_ctrl", {busy, done, error, in_mem_en, asic_start, out_mem_we}, 0);
    chk("rst_cnt", sample_cnt, 0);
    chk("rst_addr", {in_mem_addr, out_mem_addr}, 0);
    chk("rst_data", {asic_data_in, out_mem_din}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Test 1: three samples, echoing ASIC
    in_mem[0] = 16'h0100; in_mem[1] = 16'h8000; in_mem[2] = 16'hFFFF;
    key = 16'h0000;
    s0 = start_cnt; w0 = we_cnt; d0 = done_cnt;
    start_batch(3);
    wait_done(d0 + 1, 1000, "t1_done");
    chk("t1_out0", out_mem[0], 16'h0100);
    chk("t1_out1", out_mem[1], 16'h8000);
    chk("t1_out2", out_mem[2], 16'hFFFF);
    chk("t1_starts", start_cnt - s0, 3);
    chk("t1_writes", we_cnt - w0, 3);
    chk("t1_cnt", sample_cnt, 3);
    chk("t1_error", error, 0);
    wait_cycles(3);
    chk("t1_one_done", done_cnt - d0, 1);
    chk("t1_idle", busy, 0);

    // Test 2: ASIC never drops ready -> timeout
    stuck = 1'b1;
    in_mem[0] = 16'h1111; in_mem[1] = 16'h2222;
    s0 = start_cnt; w0 = we_cnt; d0 = done_cnt;
    start_batch(2);
    wait_done(d0 + 1, 6000, "t2_done");
    chk("t2_error", error, 1);
    chk("t2_writes", we_cnt - w0, 0);
    chk("t2_starts", start_cnt - s0, 1);
    chk("t2_latency", last_done_cyc - last_start_cyc, TIMEOUT + 1);
    chk("t2_cnt", sample_cnt, 0);
    stuck = 1'b0;
    wait_cycles(2);

    // Next run clears error; transformed result pins the model
    in_mem[0] = 16'h1234;
    key = 16'h5A5A;
    d0 = done_cnt;
    start_batch(1);
    chk("t2_err_clear", error, 0);
    wait_done(d0 + 1, 1000, "t2b_done");
    chk("t2b_out0", out_mem[0], 16'h486E);
    chk("t2b_error", error, 0);

    // Test 3: abort during the third WAIT_DONE
    for (int i = 0; i < 5; i++) in_mem[i] = 16'(16'h0F00 + i * 16'h0111);
    key = 16'h00FF;
    s0 = start_cnt; w0 = we_cnt; d0 = done_cnt;
    start_batch(5);
    k = 0;
    while (start_cnt - s0 < 3 && k < 1000) begin
      @(negedge clk); #1;
      k++;
    end
    chk("t3_third_start", start_cnt - s0, 3);
    wait_cycles(10);
    chk("t3_in_wait", asic_ready, 0);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_done(d0 + 1, 2, "t3_done_fast");
    chk("t3_cnt", sample_cnt, 2);
    chk("t3_writes", we_cnt - w0, 2);
    wait_cycles(80);
    chk("t3_no_more_start", start_cnt - s0, 3);
    chk("t3_idle", busy, 0);

    // Test 4: zero-length batch
    s0 = start_cnt; w0 = we_cnt; d0 = done_cnt; e0 = en_cnt;
    start_batch(0);
    @(negedge clk); #1;
    chk("t4_done_pulse", done, 1);
    chk("t4_not_busy", busy, 0);
    wait_cycles(5);
    chk("t4_one_done", done_cnt - d0, 1);
    chk("t4_no_activity", (start_cnt - s0) + (we_cnt - w0) + (en_cnt - e0), 0);

    // Test 5: run while busy ignored, then a fresh batch at index 0
    in_mem[0] = 16'hC001; in_mem[1] = 16'hC002;
    key = 16'h0000;
    w0 = we_cnt; d0 = done_cnt;
    start_batch(2);
    wait_cycles(5);
    @(posedge clk); #1; num_samples = 7; run = 1'b1;
    @(posedge clk); #1; run = 1'b0;
    wait_done(d0 + 1, 1000, "t5_done");
    chk("t5_cnt", sample_cnt, 2);
    chk("t5_writes", we_cnt - w0, 2);
    wait_cycles(3);
    chk("t5_one_done", done_cnt - d0, 1);
    in_mem[0] = 16'hA5A5;
    key = 16'h0F0F;
    d0 = done_cnt;
    start_batch(1);
    wait_done(d0 + 1, 1000, "t5b_done");
    chk("t5b_out0", out_mem[0], 16'hAAAA);
    chk("t5b_cnt", sample_cnt, 1);

    // Test 6: asynchronous reset in SETTLE
    in_mem[0] = 16'h0001; in_mem[1] = 16'h0002; in_mem[2] = 16'h0003;
    key = 16'h0000;
    w0 = we_cnt; d0 = done_cnt;
    start_batch(3);
    k = 0;
    while (we_cnt - w0 < 1 && k < 1000) begin
      @(negedge clk); #1;
      k++;
    end
    chk("t6_first_store", we_cnt - w0, 1);
    wait_cycles(5);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("t6_rst_ctrl", {busy, done, error, in_mem_en, asic_start, out_mem_we}, 0);
    chk("t6_rst_cnt", sample_cnt, 0);
    chk("t6_rst_addr", {in_mem_addr, out_mem_addr}, 0);
    chk("t6_rst_data", {asic_data_in, out_mem_din}, 0);
    wait_cycles(2);
    @(posedge clk); #1 rst = 1'b0;
    wait_cycles(20);
    chk("t6_no_done", done_cnt - d0, 0);
    in_mem[0] = 16'h7777; in_mem[1] = 16'h8888;
    w0 = we_cnt;
    start_batch(2);
    wait_done(d0 + 1, 1000, "t6b_done");
    chk("t6b_cnt", sample_cnt, 2);
    chk("t6b_writes", we_cnt - w0, 2);
    chk("t6b_out1", out_mem[1], 16'h8888);
    chk("t6b_error", error, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/asic_sample_sequencer.md
Name: asic_sample_sequencer

Overview:
- Batch controller for the ASIC function interface (PMOD DAC drive plus XADC readback).
- Walks an input sample memory, launches one DAC→XADC conversion per sample, and enforces a settle gap between samples.
- Writes each 16-bit XADC result to an output sample memory at the same index.
- Sits between the SoC register/DMA logic (run/status) and the function interface; the reservoir computation drives it as its sole user.

Parameters:
ADDR_WIDTH, 15, sample memory address width (max 2**ADDR_WIDTH samples)
DATA_WIDTH, 16, sample and result width
SETTLE_CYCLES, 16, minimum idle clocks between result capture and the next launch
TIMEOUT_CYCLES, 4096, maximum clocks spent in WAIT_BUSY plus WAIT_DONE per sample before an error is flagged

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
run  in  1  start a batch; honoured only in IDLE
abort  in  1  stop the batch; honoured in any non-IDLE state
num_samples  in  ADDR_WIDTH+1  batch length; latched when run is accepted
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a batch ends (normal end, abort, or error)
error  out  1  sticky timeout flag; cleared when the next run is accepted
sample_cnt  out  ADDR_WIDTH+1  number of results stored in the current batch
in_mem_addr  out  ADDR_WIDTH  input memory read address
in_mem_en  out  1  input memory read enable; data is returned 1 cycle later
in_mem_dout  in  DATA_WIDTH  input memory read data
asic_start  out  1  one-cycle launch pulse to the function interface
asic_data_in  out  DATA_WIDTH  DAC code, registered and held stable from launch until the next fetch
asic_ready  in  1  function interface idle / result valid (its xadc_data_valid)
asic_result  in  DATA_WIDTH  registered XADC result
out_mem_addr  out  ADDR_WIDTH  output memory write address
out_mem_we  out  1  output memory write strobe, one cycle
out_mem_din  out  DATA_WIDTH  output memory write data

Behaviour:
- Reset: state is IDLE; all outputs are 0; the internal index, settle counter and timeout counter are 0.
- Single registered FSM. All outputs are registered except asic_start, in_mem_en and out_mem_we, which decode from the state.
- IDLE
  - run=1 and num_samples=0: clear error, pulse done next cycle, stay IDLE.
  - run=1 and num_samples>0: latch N, set idx=0, sample_cnt=0, clear error, go to FETCH.
- FETCH: in_mem_en=1, in_mem_addr=idx; go to LOAD.
- LOAD: capture in_mem_dout into asic_data_in; go to LAUNCH.
- LAUNCH
  - asic_ready=1: asic_start=1 for this cycle only; go to WAIT_BUSY.
  - asic_ready=0: stay in LAUNCH.
- WAIT_BUSY: wait for asic_ready=0, then go to WAIT_DONE.
  - asic_ready stays high in the launch cycle, so it must be seen low before any completion is accepted.
- WAIT_DONE: on asic_ready=1, go to STORE.
- STORE
  - out_mem_we=1, out_mem_addr=idx, out_mem_din=asic_result.
  - sample_cnt increments; idx increments.
  - If the new sample_cnt equals N, go to FINISH; otherwise go to SETTLE.
- SETTLE: count SETTLE_CYCLES clocks, then go to FETCH. SETTLE_CYCLES=0 means go to FETCH directly.
- FINISH: done=1 for one cycle; go to IDLE.
- Timeout
  - The counter resets on entry to WAIT_BUSY and runs through WAIT_BUSY and WAIT_DONE.
  - On reaching TIMEOUT_CYCLES: set error=1 and go to FINISH.
  - No memory write for that sample; sample_cnt keeps its value.
- Abort
  - Go to FINISH from any non-IDLE state on the next edge.
  - A STORE cycle coinciding with abort still completes its write.
  - Abort has priority over every other transition.
- run while busy is ignored. A run and abort in the same cycle in IDLE: run wins; abort is ignored in IDLE.
- Address wrap: idx is ADDR_WIDTH+1 bits; memory addresses use the low ADDR_WIDTH bits.
  - num_samples above 2**ADDR_WIDTH is clamped to 2**ADDR_WIDTH when latched.
- Steady-state per-sample cost: 4 + ASIC latency + 1 + SETTLE_CYCLES clocks.
- Asynchronous rst mid-batch: return to IDLE immediately and deassert all strobes. No done pulse.

Test Plan:
- N=3, input mem {0x0100,0x8000,0xFFFF}, ASIC model echoes its input after 40 clks → out mem {0x0100,0x8000,0xFFFF}; exactly 3 asic_start pulses; done once; sample_cnt=3; error=0.
- Launch spacing with SETTLE_CYCLES=16 → at least 16 clocks from each out_mem_we to the next in_mem_en; asic_data_in stable from launch until the result is stored.
- ASIC model never drops asic_ready → timeout after 4096 clks; error=1; done pulse; no out_mem_we; next run clears error.
- N=5, abort asserted during the 3rd WAIT_DONE → done within 2 clks; sample_cnt=2; no further asic_start.
- num_samples=0 → done pulse 1 clk after run; no memory or ASIC activity. Also: run while busy is ignored, and a second run after done starts a fresh batch at idx 0.
- Assert rst mid-SETTLE → all outputs 0 the same cycle; no done pulse; a subsequent run behaves normally.
